// File: rtl/semaforo_escalonador.sv
// Demand-actuated two-road traffic light sequencer.
// Road A rests green; road B is served only after a latched request on bt.
// Every yellow is followed by an all-red clearance before the crossing road
// turns green. All outputs come straight from registers.
module semaforo_escalonador #(
  parameter int unsigned T_VERDE_A_MIN = 8,
  parameter int unsigned T_AMARELO     = 3,
  parameter int unsigned T_VERMELHO    = 2,
  parameter int unsigned T_VERDE_B     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       req_pend,
  output logic [2:0] fase
);

  typedef enum logic [2:0] {
    A_VERDE   = 3'd0,
    A_AMARELO = 3'd1,
    VERM1     = 3'd2,
    B_VERDE   = 3'd3,
    B_AMARELO = 3'd4,
    VERM2     = 3'd5
  } fase_t;

  // Lamp encoding: bit2 vermelho, bit1 amarelo, bit0 verde.
  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERMELHO = 3'b100;

  fase_t      estado;
  logic [7:0] cnt;
  fase_t      prox;
  logic       fim_fase;

  // Fixed phase ring; A_VERDE only leaves it when a request is pending.
  function automatic fase_t seguinte(input fase_t f);
    case (f)
      A_VERDE:   return A_AMARELO;
      A_AMARELO: return VERM1;
      VERM1:     return B_VERDE;
      B_VERDE:   return B_AMARELO;
      B_AMARELO: return VERM2;
      default:   return A_VERDE;
    endcase
  endfunction

  // Counter load value on entry: a phase of T cycles counts T-1 down to 0.
  function automatic logic [7:0] carga(input fase_t f);
    case (f)
      A_VERDE:             return 8'(T_VERDE_A_MIN - 1);
      A_AMARELO, B_AMARELO: return 8'(T_AMARELO - 1);
      B_VERDE:             return 8'(T_VERDE_B - 1);
      default:             return 8'(T_VERMELHO - 1);
    endcase
  endfunction

  function automatic logic [2:0] lampada_a(input fase_t f);
    case (f)
      A_VERDE:   return VERDE;
      A_AMARELO: return AMARELO;
      default:   return VERMELHO;
    endcase
  endfunction

  function automatic logic [2:0] lampada_b(input fase_t f);
    case (f)
      B_VERDE:   return VERDE;
      B_AMARELO: return AMARELO;
      default:   return VERMELHO;
    endcase
  endfunction

  // A phase ends once its count has run out; A green additionally waits for demand.
  assign fim_fase = (cnt == 8'd0) && ((estado != A_VERDE) || req_pend);
  assign prox     = seguinte(estado);

  // The phase code is the state register itself, so it stays aligned with A and B.
  assign fase = estado;

  // Phase sequencing, timing counter, lamp registers and request latch.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and every register, lamps included, is given its rest value on that edge.
    if (rst) begin
      estado   <= A_VERDE;
      cnt      <= carga(A_VERDE);
      A        <= VERDE;
      B        <= VERMELHO;
      req_pend <= 1'b0;
    end else begin
      if (fim_fase) begin
        estado <= prox;
        cnt    <= carga(prox);
        // Lamps decoded from the next phase so they switch on the same edge as fase.
        A      <= lampada_a(prox);
        B      <= lampada_b(prox);
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end

      // Entering B green consumes the request and beats a simultaneous press;
      // presses during B green are dropped since B is already being served.
      if (fim_fase && (estado == VERM1)) begin
        req_pend <= 1'b0;
      end else if (bt && (estado != B_VERDE)) begin
        req_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_semaforo_escalonador.sv
// Self-checking bench for semaforo_escalonador: a default-parameter instance
// and an all-ones-parameter instance share clk/rst/bt. Both are compared every
// cycle against a phase/elapsed-time model and a safety monitor; directed
// scenarios add table-driven and hand-written checks on the default instance.
module tb_semaforo_escalonador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bt  = 1'b0;
  logic [2:0] a0, b0, f0, a1, b1, f1;
  logic       r0, r1;

  semaforo_escalonador dut (
    .clk(clk), .rst(rst), .bt(bt),
    .A(a0), .B(b0), .req_pend(r0), .fase(f0)
  );

  semaforo_escalonador #(
    .T_VERDE_A_MIN(1), .T_AMARELO(1), .T_VERMELHO(1), .T_VERDE_B(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bt(bt),
    .A(a1), .B(b1), .req_pend(r1), .fase(f1)
  );

  always #5 clk = ~clk;

  // Reference model: phase index, cycles elapsed inside it, pending request.
  typedef struct {
    int p;
    int e;
    bit req;
  } mdl_t;

  typedef struct {
    int         first;
    int         last;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] f;
    logic       req;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         dur [2][6];
  logic [2:0] a_ref [6];
  logic [2:0] b_ref [6];
  mdl_t       m [2];
  int         red_run [2];
  bit         pa_g [2];
  bit         pb_g [2];
  vec_t       tbl [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic mdl_t step(input int k, input mdl_t cur, input logic r, input logic b);
    mdl_t nx;
    bit   done;
    nx = cur;
    if (r) begin
      nx.p = 0; nx.e = 0; nx.req = 1'b0;
      return nx;
    end
    done = (cur.e + 1 >= dur[k][cur.p]) && (cur.p != 0 || cur.req);
    if (done && cur.p == 2)      nx.req = 1'b0;
    else if (b && cur.p != 3)    nx.req = 1'b1;
    if (done) begin
      nx.p = (cur.p + 1) % 6; nx.e = 0;
    end else begin
      nx.e = cur.e + 1;
    end
    return nx;
  endfunction

  task automatic inv_check(input int k, input logic [2:0] la, input logic [2:0] lb, input logic r);
    bit ag, bg;
    check($sformatf("onehot_A%0d", k), 32'($onehot(la)), 32'd1);
    check($sformatf("onehot_B%0d", k), 32'($onehot(lb)), 32'd1);
    check($sformatf("conflict%0d", k), 32'((la != 3'b100) && (lb != 3'b100)), 32'd0);
    ag = (la == 3'b001);
    bg = (lb == 3'b001);
    if (!r) begin
      if (ag && !pa_g[k])
        check($sformatf("clear_before_A%0d", k), 32'(red_run[k] >= dur[k][2]), 32'd1);
      if (bg && !pb_g[k])
        check($sformatf("clear_before_B%0d", k), 32'(red_run[k] >= dur[k][2]), 32'd1);
      red_run[k] = (la == 3'b100 && lb == 3'b100) ? red_run[k] + 1 : 0;
    end else begin
      red_run[k] = 0;
    end
    pa_g[k] = ag;
    pb_g[k] = bg;
  endtask

  // One clock edge: advance the models with the inputs seen at the edge, then
  // sample and compare both instances a little after it.
  task automatic tick();
    logic r_s;
    int   exp_cnt;
    @(posedge clk);
    r_s = rst;
    for (int k = 0; k < 2; k++) m[k] = step(k, m[k], rst, bt);
    #1;
    if (r_s) cyc = 0;
    else     cyc++;
    check("mdl_A0",   a0, a_ref[m[0].p]);
    check("mdl_B0",   b0, b_ref[m[0].p]);
    check("mdl_fase0", f0, 32'(m[0].p));
    check("mdl_req0", r0, m[0].req);
    exp_cnt = dur[0][m[0].p] - 1 - m[0].e;
    if (exp_cnt < 0) exp_cnt = 0;
    check("mdl_cnt0", dut.cnt, 32'(exp_cnt));
    check("mdl_A1",   a1, a_ref[m[1].p]);
    check("mdl_B1",   b1, b_ref[m[1].p]);
    check("mdl_fase1", f1, 32'(m[1].p));
    check("mdl_req1", r1, m[1].req);
    inv_check(0, a0, b0, r_s);
    inv_check(1, a1, b1, r_s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bt  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_table(input int c);
    for (int i = 0; i < 8; i++) begin
      if (c >= tbl[i].first && c <= tbl[i].last) begin
        check("tbl_A",    a0, tbl[i].a);
        check("tbl_B",    b0, tbl[i].b);
        check("tbl_fase", f0, tbl[i].f);
        check("tbl_req",  r0, tbl[i].req);
      end
    end
  endtask

  initial begin
    dur[0] = '{8, 3, 2, 6, 3, 2};
    dur[1] = '{1, 1, 1, 1, 1, 1};
    a_ref  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    b_ref  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 2; k++) begin
      m[k] = '{p: 0, e: 0, req: 1'b0};
      red_run[k] = 0; pa_g[k] = 1'b0; pb_g[k] = 1'b0;
    end

    // Basic service with bt at cycle 2 only.
    tbl[0] = '{first: 0,  last: 1,  a: 3'b001, b: 3'b100, f: 3'd0, req: 1'b0};
    tbl[1] = '{first: 2,  last: 7,  a: 3'b001, b: 3'b100, f: 3'd0, req: 1'b1};
    tbl[2] = '{first: 8,  last: 10, a: 3'b010, b: 3'b100, f: 3'd1, req: 1'b1};
    tbl[3] = '{first: 11, last: 12, a: 3'b100, b: 3'b100, f: 3'd2, req: 1'b1};
    tbl[4] = '{first: 13, last: 18, a: 3'b100, b: 3'b001, f: 3'd3, req: 1'b0};
    tbl[5] = '{first: 19, last: 21, a: 3'b100, b: 3'b010, f: 3'd4, req: 1'b0};
    tbl[6] = '{first: 22, last: 23, a: 3'b100, b: 3'b100, f: 3'd5, req: 1'b0};
    tbl[7] = '{first: 24, last: 40, a: 3'b001, b: 3'b100, f: 3'd0, req: 1'b0};

    do_reset();
    check_table(0);
    for (int c = 1; c <= 40; c++) begin
      bt = (c == 2);
      tick();
      check_table(c);
    end

    // No demand: rest in A green, counter parked at zero from cycle 7.
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      bt = 1'b0;
      tick();
      check("idle_fase", f0, 32'd0);
      check("idle_A", a0, 32'h1);
      check("idle_B", b0, 32'h4);
      check("idle_cnt", dut.cnt, (c >= 7) ? 32'd0 : 32'(7 - c));
    end

    // Late request during B yellow is served in the next cycle of phases.
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      bt = (c == 2 || c == 20);
      tick();
      if (c >= 20 && c <= 31) check("late_req", r0, 32'd1);
      if (c >= 24 && c <= 31) check("late_A_green", a0, 32'h1);
      if (c == 32)            check("late_A_yellow", a0, 32'h2);
    end

    // Press during B green is ignored.
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      bt = (c == 2 || c == 15);
      tick();
      if (c >= 13) check("ign_req", r0, 32'd0);
      if (c >= 24) check("ign_A", a0, 32'h1);
    end

    // bt held across the edge entering B green: clear wins.
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      bt = (c >= 2 && c <= 13);
      tick();
      if (c >= 13) check("coll_req", r0, 32'd0);
      if (c >= 24) check("coll_fase", f0, 32'd0);
    end
    bt = 1'b0;

    // Reset in the middle of B green, then minimum A green is honoured again.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      bt  = (c == 2);
      rst = (c == 16);
      tick();
    end
    rst = 1'b0;
    check("rst_A", a0, 32'h1);
    check("rst_B", b0, 32'h4);
    check("rst_fase", f0, 32'd0);
    check("rst_req", r0, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      bt = (c == 1);
      tick();
      check("rst_yield", f0, (c < 8) ? 32'd0 : 32'd1);
    end

    // Random traffic with occasional resets, checked by model and monitor.
    for (int c = 0; c < 3000; c++) begin
      bt  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bt  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/semaforo_escalonador.md
Name: semaforo_escalonador

Overview:
- Demand-actuated sequencer for a two-road intersection. Main road A rests green; secondary road B gets a green phase only after a latched request on bt.
- Owns all phase timing and inserts an all-red clearance between conflicting greens.
- Drives the 3-bit lamp vectors for both heads and exposes phase and request status for the top level and for debug.

Parameters:
- T_VERDE_A_MIN, 8, minimum A green cycles before A may yield (1..255)
- T_AMARELO, 3, yellow cycles for either road (1..255)
- T_VERMELHO, 2, all-red clearance cycles after each yellow (1..255)
- T_VERDE_B, 6, B green cycles (1..255)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- bt   input  1  B/pedestrian request, level-sampled every rising edge
- A    output 3  road A lamps: bit2 vermelho, bit1 amarelo, bit0 verde (one-hot)
- B    output 3  road B lamps, same encoding
- req_pend  output  1  latched request pending
- fase output 3  current phase code 0..5

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Phases and outputs:
  - 0 A_VERDE: A=001, B=100
  - 1 A_AMARELO: A=010, B=100
  - 2 VERM1: A=100, B=100
  - 3 B_VERDE: A=100, B=001
  - 4 B_AMARELO: A=100, B=010
  - 5 VERM2: A=100, B=100
- All outputs are registered. fase, A and B change on the same edge.
- Counter: 8-bit cnt.
  - Loaded with T_x-1 on the edge that enters phase x.
  - Decrements each edge while nonzero; holds at 0.
  - A phase lasts exactly T_x cycles. A_VERDE lasts at least that long.
- Transitions, evaluated when cnt==0:
  - A_VERDE -> A_AMARELO only if req_pend=1; otherwise stay, cnt held at 0.
  - A_AMARELO -> VERM1 -> B_VERDE -> B_AMARELO -> VERM2 -> A_VERDE, unconditional.
- Request latch:
  - req_pend set on any edge with bt=1, except in B_VERDE and on the edge entering B_VERDE.
  - req_pend is cleared on the edge entering B_VERDE. Clear wins over a simultaneous bt.
  - bt during B_VERDE is ignored.
  - bt during B_AMARELO or VERM2 is latched and serviced in the next cycle of phases.
- Request-to-yield latency:
  - bt sampled at an edge gives req_pend=1 after that edge.
  - The earliest A_AMARELO is the edge after both req_pend=1 and cnt==0.
- Reset, on any edge with rst=1 regardless of phase, including mid-operation:
  - fase=0, A=001, B=100, req_pend=0, cnt=T_VERDE_A_MIN-1.
  - rst overrides bt.
- Safety invariants, checked every cycle:
  - A and B are never both non-red.
  - A and B are always one-hot.
  - Every green is preceded by a red of at least T_VERMELHO cycles on the other road.
- Parameter value 0 is illegal; no behaviour is defined for it.

Test Plan:
Cycle n = n-th rising edge after the last edge with rst=1, which is cycle 0. Values are those after the edge. Default parameters unless stated.
- Basic service: bt=1 at cycle 2 only -> req_pend=1 from 2; A=001 cycles 0-7; A=010 cycles 8-10; all-red 11-12; B=001 cycles 13-18, req_pend=0 from 13; B=010 cycles 19-21; all-red 22-23; A=001 from 24 and held indefinitely.
- No demand: bt=0 for 100 cycles -> fase=0, A=001, B=100 throughout; cnt holds 0 from cycle 7.
- Late request: as basic case plus bt=1 at cycle 20 (B_AMARELO) -> req_pend stays 1; A green cycles 24-31; A=010 at cycle 32.
- Ignored press: as basic case plus bt=1 at cycle 15 (B_VERDE) -> req_pend=0; A stays green from 24 onward.
- Clear-vs-set collision: bt held 1 from cycle 2 through cycle 13 -> req_pend=0 after cycle 13; no second B phase after returning to A_VERDE at 24.
- Reset mid-phase: rst=1 at cycle 16 (B green) -> after that edge A=001, B=100, fase=0, req_pend=0. The next bt gives A_AMARELO no earlier than 8 cycles after the reset edge.
- Invariant monitor: the safety checks run throughout all scenarios, including a run with all parameters set to 1.
